// File: rtl/out_pkg.sv
// Shared constants and types for the output deskew array.
// Holds the default lane count and width, the lane/vector types, and the
// frame-boundary helper used when tagging FIFO pushes.
package out_pkg;

    localparam int DEF_LANES = 25;
    localparam int DEF_DW    = 16;

    typedef logic [DEF_DW-1:0] lane_t;
    typedef lane_t [DEF_LANES-1:0] vec_t;

    // True when a push at frame position cnt closes a frame of length len.
    // len == 0 wraps to 255 in 8 bits, which gives a 256-vector frame.
    function automatic logic frame_last(input logic [7:0] cnt, input logic [7:0] len);
        return cnt == (len - 8'd1);
    endfunction

endpackage

// File: rtl/output_deskew_array_deskew_lane.sv
// One lane of the deskew delay: DEPTH registers carrying {vld, data}.
// DEPTH == 0 is a plain wire pass-through.
module deskew_lane #(
    parameter int DEPTH = 0,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [W-1:0] data,
    input  logic         vld,
    output logic [W-1:0] data_dly,
    output logic         vld_dly
);

    if (DEPTH == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ nrst;
        assign data_dly = data;
        assign vld_dly  = vld;
    end else begin : g_dly
        logic [DEPTH-1:0] vld_sr;
        logic [W-1:0]     data_sr [DEPTH];

        // Valid shift register; cleared on reset so stale data is never used.
        // NOTE: non-blocking assignments make every stage take the previous stage's old value.
        always_ff @(posedge clk or posedge nrst) begin
            if (nrst) begin
                vld_sr <= '0;
            end else begin
                vld_sr[0] <= vld;
                for (int k = 1; k < DEPTH; k++) vld_sr[k] <= vld_sr[k-1];
            end
        end

        // Data shift register, free-running.
        // NOTE: data stages carry no reset; the valid bits gate every downstream use.
        always_ff @(posedge clk) begin
            data_sr[0] <= data;
            for (int k = 1; k < DEPTH; k++) data_sr[k] <= data_sr[k-1];
        end

        assign data_dly = data_sr[DEPTH-1];
        assign vld_dly  = vld_sr[DEPTH-1];
    end

endmodule

// File: rtl/output_deskew_array.sv
// Output deskew array: realigns LANES skewed column results (lane i trails
// lane 0 by i cycles) into whole vectors, tags frame boundaries, and queues
// them in a FIFO with valid/ready output.
// Pipeline: deskew lines -> aligned register -> write register -> FIFO, so a
// vector appears at the output LANES+1 edges after lane 0 was sampled.
// Optional macro OUT_RELU_EN: zero negative lanes before they enter the FIFO.
module output_deskew_array
    import out_pkg::*;
#(
    parameter int LANES      = DEF_LANES,
    parameter int DW         = DEF_DW,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [LANES-1:0][DW-1:0]  data_in,
    input  logic [LANES-1:0]          in_vld,
    input  logic [7:0]                frame_len,
    output logic [LANES-1:0][DW-1:0]  data_out,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic                      out_last,
    output logic                      align_err,
    output logic                      ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef logic [LANES-1:0][DW-1:0] row_t;

    // Deskew delay lines
    row_t             dly_data;
    logic [LANES-1:0] dly_vld;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        deskew_lane #(
            .DEPTH (LANES - 1 - i),
            .W     (DW)
        ) u_lane (
            .clk      (clk),
            .nrst     (nrst),
            .data     (data_in[i]),
            .vld      (in_vld[i]),
            .data_dly (dly_data[i]),
            .vld_dly  (dly_vld[i])
        );
    end

    logic lane_mismatch;
    assign lane_mismatch = (|dly_vld) && !(&dly_vld);

    // Aligned and write stages
    logic al_vld, wr_vld;
    row_t al_data, relu_data, wr_data;

    // Stage valids: aligned valid is the AND of all delayed lane valids.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            al_vld <= 1'b0;
            wr_vld <= 1'b0;
        end else begin
            al_vld <= &dly_vld;
            wr_vld <= al_vld;
        end
    end

    // Stage data, gated downstream by the stage valids.
    always_ff @(posedge clk) begin
        al_data <= dly_data;
        wr_data <= relu_data;
    end

`ifdef OUT_RELU_EN
    // Zero any lane whose two's complement value is negative.
    always_comb begin
        // NOTE: default assignment first so every path drives relu_data (no latch).
        relu_data = al_data;
        for (int l = 0; l < LANES; l++) begin
            if (al_data[l][DW-1]) relu_data[l] = '0;
        end
    end
`else
    assign relu_data = al_data;
`endif

    // FIFO
    logic [AW:0]           wr_ptr, rd_ptr;
    row_t                  mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_mem;
    logic                  empty, full, push, pop, drop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && out_rdy;
    assign push  = wr_vld && (!full || pop);
    assign drop  = wr_vld && full && !pop;

    // Frame tagging
    logic [7:0] frame_cnt, len_q, eff_len;
    logic       push_last;

    assign eff_len   = (frame_cnt == 8'd0) ? frame_len : len_q;
    assign push_last = frame_last(frame_cnt, eff_len);

    // FIFO storage write; contents are only visible through out_vld.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]]      <= wr_data;
            last_mem[wr_ptr[AW-1:0]] <= push_last;
        end
    end

    // Pointers, frame counter and sticky flags.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            frame_cnt <= '0;
            len_q     <= '0;
            align_err <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + PTR_ONE;
                frame_cnt <= push_last ? 8'd0 : frame_cnt + 8'd1;
                len_q     <= eff_len;
            end
            if (pop)           rd_ptr    <= rd_ptr + PTR_ONE;
            if (lane_mismatch) align_err <= 1'b1;
            if (drop)          ovf       <= 1'b1;
        end
    end

    assign out_vld  = !empty;
    assign data_out = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign out_last = !empty && last_mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_output_deskew_array.sv
// Randomized scoreboard bench for output_deskew_array. Stimulus tasks skew
// each vector across the lanes and push the expected aligned vector, computed
// from the lane values, frame length and ReLU rule (OUT_RELU_EN), into a queue;
// a monitor pops and compares on every output handshake.
module tb_output_deskew_array;
    import out_pkg::*;

    localparam int LANES      = DEF_LANES;
    localparam int DW         = DEF_DW;
    localparam int FIFO_DEPTH = 4;
    localparam int LAT        = LANES + 1;
    localparam int CW         = LANES * DW;

    logic             clk = 1'b0;
    logic             nrst;
    vec_t             data_in;
    logic [LANES-1:0] in_vld;
    logic [7:0]       frame_len;
    vec_t             data_out;
    logic             out_vld, out_rdy, out_last, align_err, ovf;

    output_deskew_array #(
        .LANES(LANES), .DW(DW), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .nrst(nrst), .data_in(data_in), .in_vld(in_vld),
        .frame_len(frame_len), .data_out(data_out), .out_vld(out_vld),
        .out_rdy(out_rdy), .out_last(out_last), .align_err(align_err), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct { vec_t data; logic [LANES-1:0] mask; } sched_t;
    typedef struct { vec_t data; logic last; int lat_edge; } exp_t;

    sched_t sched [int];
    exp_t   sb [$];
    int     n_checks = 0;
    int     n_fails  = 0;
    int     m_cnt    = 0;
    int     m_len    = 0;
    int     t_start;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t relu_vec(input vec_t v);
        vec_t r;
        r = v;
`ifdef OUT_RELU_EN
        for (int l = 0; l < LANES; l++) if ($signed(v[l]) < 0) r[l] = '0;
`endif
        return r;
    endfunction

    function automatic vec_t make_vec(input int base);
        vec_t v;
        for (int l = 0; l < LANES; l++) v[l] = lane_t'(base + l);
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int l = 0; l < LANES; l++) v[l] = lane_t'($urandom);
        return v;
    endfunction

    // Schedule a vector whose lane 0 is sampled on the next edge. Complete
    // vectors that the FIFO will accept advance the frame model.
    task automatic issue(input vec_t v, input logic [LANES-1:0] mask, input bit accepted, input bit chk_lat);
        int   s;
        logic last;
        s = edge_n + 1;
        sched[s] = '{data: v, mask: mask};
        if (mask == '1 && accepted) begin
            if (m_cnt == 0) m_len = (frame_len == 8'd0) ? 256 : int'(frame_len);
            m_cnt++;
            last = (m_cnt == m_len);
            if (last) m_cnt = 0;
            sb.push_back('{data: relu_vec(v), last: last, lat_edge: chk_lat ? s + LAT : -1});
        end
    endtask

    // Drive lane i with the vector whose lane 0 was sampled i edges earlier.
    task automatic tick();
        int e;
        e = edge_n + 1;
        for (int l = 0; l < LANES; l++) begin
            if (sched.exists(e - l)) begin
                data_in[l] = sched[e - l].data[l];
                in_vld[l]  = sched[e - l].mask[l];
            end else begin
                data_in[l] = lane_t'($urandom);
                in_vld[l]  = 1'b0;
            end
        end
        if (sched.exists(e - LANES)) sched.delete(e - LANES);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while (sb.size() > 0 && c < budget) begin
            tick();
            c++;
        end
        n_checks++;
        if (sb.size() > 0) begin
            n_fails++;
            $display("FAIL drain_timeout: got %0d vectors outstanding expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        nrst = 1'b1;
        #1;
        check("rst_out_vld", out_vld, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_data_out", data_out, '0);
        check("rst_align_err", align_err, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        sched.delete();
        sb.delete();
        m_cnt = 0;
        idle(2);
        nrst = 1'b0;
    endtask

    // Monitor: compares on each handshake and checks hold under backpressure.
    exp_t mon_e;
    bit   have_prev = 1'b0;
    logic prev_rdy, prev_last;
    vec_t prev_data;

    always @(negedge clk) begin
        #1;
        if (!nrst && out_vld) begin
            if (have_prev && !prev_rdy) begin
                check("hold_data", data_out, prev_data);
                check("hold_last", out_last, prev_last);
            end
            if (out_rdy) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL unexpected_output: got %0h expected no vector", data_out);
                end else begin
                    mon_e = sb.pop_front();
                    check("data_out", data_out, mon_e.data);
                    check("out_last", out_last, mon_e.last);
                    if (mon_e.lat_edge >= 0) check("latency_edge", edge_n, mon_e.lat_edge);
                end
            end
            have_prev = 1'b1;
            prev_rdy  = out_rdy;
            prev_data = data_out;
            prev_last = out_last;
        end else begin
            have_prev = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        logic [LANES-1:0] m;

        nrst      = 1'b1;
        out_rdy   = 1'b1;
        frame_len = 8'd3;
        in_vld    = '0;
        data_in   = '0;
        idle(3);
        do_reset();

        // Single vector, lanes 100+i, with latency check.
        issue(make_vec(100), '1, 1'b1, 1'b1);
        drain(LAT + 20);
        idle(4);
        check("align_err_clean", align_err, 1'b0);

        // Lane 7 valid missing: no write, sticky error.
        m = '1;
        m[7] = 1'b0;
        issue(make_vec(200), m, 1'b1, 1'b0);
        idle(LAT + 6);
        check("align_err_set", align_err, 1'b1);
        check("no_out_after_err", out_vld, 1'b0);
        issue(make_vec(250), '1, 1'b1, 1'b0);
        drain(LAT + 20);
        check("align_err_sticky", align_err, 1'b1);

        // Push and pop together while full: all five arrive.
        do_reset();
        out_rdy = 1'b0;
        t_start = edge_n + 1;
        for (int c = 0; c < LAT + 12; c++) begin
            if (c < 5) issue(make_vec(400 + 32 * c), '1, 1'b1, 1'b0);
            out_rdy = (edge_n + 1 >= t_start + 4 + LAT);
            tick();
        end
        drain(40);
        check("full_pushpop_ovf", ovf, 1'b0);

        // Six vectors against a stalled consumer: four held, overflow flagged.
        out_rdy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            issue(make_vec(600 + 32 * k), '1, k < FIFO_DEPTH, 1'b0);
            tick();
        end
        idle(LAT + 8);
        check("ovf_set", ovf, 1'b1);
        check("held_out_vld", out_vld, 1'b1);
        out_rdy = 1'b1;
        drain(20);
        idle(4);

        // Reset mid-frame with two vectors in flight.
        frame_len = 8'd3;
        issue(make_vec(900), '1, 1'b1, 1'b0);
        drain(LAT + 20);
        issue(make_vec(950), '1, 1'b1, 1'b0);
        tick();
        issue(make_vec(980), '1, 1'b1, 1'b0);
        idle(10);
        do_reset();
        frame_len = 8'd1;
        issue(make_vec(1000), '1, 1'b1, 1'b0);
        drain(LAT + 20);
        idle(LAT + 4);

        // frame_len = 3 over nine vectors: last on 3, 6, 9.
        frame_len = 8'd3;
        for (int k = 0; k < 9; k++) begin
            issue(make_vec(1100 + 32 * k), '1, 1'b1, 1'b0);
            tick();
        end
        drain(LAT + 30);

        // ReLU vector: lane 3 negative, lane 4 positive.
        v = make_vec(1500);
        v[3] = 16'hFF00;
        v[4] = 16'h0010;
        issue(v, '1, 1'b1, 1'b0);
        drain(LAT + 20);

        // Random traffic and backpressure.
        frame_len = 8'($urandom_range(1, 5));
        for (int c = 0; c < 300; c++) begin
            if (sb.size() < FIFO_DEPTH && $urandom_range(0, 9) < 6)
                issue(rand_vec(), '1, 1'b1, 1'b0);
            out_rdy = ($urandom_range(0, 9) < 7);
            tick();
        end
        out_rdy = 1'b1;
        drain(LAT + 40);

        // frame_len = 0 means 256 vectors per frame.
        frame_len = 8'd0;
        for (int k = 0; k < 260; k++) begin
            issue(rand_vec(), '1, 1'b1, 1'b0);
            tick();
        end
        drain(LAT + 40);
        idle(4);
        check("final_ovf", ovf, 1'b0);
        check("final_align_err", align_err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/output_deskew_array.md
OUTPUT_DESKEW_ARRAY -- requirements
Module: output_deskew_array

Interface
REQ-001 SHALL have parameter LANES, default 25; number of array columns and skewed output lanes.
REQ-002 SHALL have parameter DW, default 16; lane data width in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4; depth of the aligned-vector output FIFO (power of 2, at least 2).
REQ-004 SHALL have port clk, input, 1; the single clock, with all state on its rising edge.
REQ-005 SHALL have port nrst, input, 1; asynchronous, active-high reset (name kept for codebase consistency).
REQ-006 SHALL have port data_in, input, LANES x DW; skewed column results, where lane i trails lane 0 by i cycles.
REQ-007 SHALL have port in_vld, input, LANES; per-lane valid, skewed the same as data_in.
REQ-008 SHALL have port frame_len, input, 8; aligned vectors per frame, sampled only while the frame counter is 0.
REQ-009 SHALL have port data_out, output, LANES x DW; aligned vector at the FIFO head.
REQ-010 SHALL have port out_vld, output, 1; data_out is valid.
REQ-011 SHALL have port out_rdy, input, 1; consumer accepts a vector when out_vld and out_rdy are both high.
REQ-012 SHALL have port out_last, output, 1; the current head vector is the last of its frame.
REQ-013 SHALL have port align_err, output, 1; sticky flag for a lane-valid mismatch.
REQ-014 SHALL have port ovf, output, 1; sticky flag for an aligned vector dropped because the FIFO was full.

Function
REQ-015 Lane i SHALL pass through a free-running delay of LANES-1-i registers carrying {in_vld[i], data_in[i]}, so lane LANES-1 has zero delay.
REQ-016 Aligned valid SHALL be the AND of all delayed lane valids; the aligned data SHALL be the concatenation of the delayed lane data.
REQ-017 If some, but not all, delayed lane valids are high in a cycle, align_err SHALL set, and no FIFO write occurs that cycle.
REQ-018 An aligned-valid cycle SHALL write one vector into the FIFO, registered on the next edge.
- With the FIFO empty and out_rdy high, out_vld SHALL rise LANES+1 edges after the edge that sampled lane-0 in_vld.
REQ-019 An aligned-valid cycle with the FIFO full and no pop in the same cycle SHALL drop the vector and set ovf.
- A simultaneous push and pop when full SHALL succeed without loss.
REQ-020 A simultaneous push and pop when empty SHALL give out_vld the following cycle; there is no combinational bypass.
REQ-021 out_vld SHALL equal FIFO not-empty; data_out and out_last SHALL hold stable while out_vld is high and out_rdy is low.
REQ-022 The frame counter SHALL increment on each FIFO push.
- out_last SHALL be tagged on the push where count == frame_len-1, after which the counter wraps to 0.
- frame_len == 0 SHALL be treated as 256.
REQ-023 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH, using an extra bit to tell full from empty.

Reset
REQ-024 Asserting nrst SHALL, asynchronously:
- clear all delay-line valid bits, the FIFO pointers, the frame counter, align_err and ovf;
- drive out_vld=0, out_last=0 and data_out=0.
REQ-025 Delay-line data registers need not be reset; valid bits SHALL gate all downstream use of them.
REQ-026 Reset asserted mid-frame SHALL discard in-flight vectors; the first post-reset vector SHALL start a new frame at count 0.

Configuration
REQ-027 With OUT_RELU_EN defined, each lane SHALL be replaced by 0 at FIFO write when its data is negative (two's complement MSB=1).
REQ-028 Without OUT_RELU_EN, data SHALL pass unmodified; no comparison logic SHALL be present.

Structure
REQ-029 Package out_pkg SHALL hold:
- LANES and DW defaults;
- typedef lane_t (logic [DW-1:0]);
- typedef vec_t (lane_t [LANES-1:0]).
REQ-030 A sub-module deskew_lane (parameter DEPTH, with zero-depth pass-through) SHALL implement one lane's delay, instantiated LANES times by generate.

Verification
REQ-031 Single vector with lanes i=0..24 carrying value 100+i, skewed by i cycles, out_rdy=1 -> one out_vld pulse 26 edges after lane 0, data_out[i]=100+i, align_err=0.
REQ-032 Lane 7 in_vld dropped for its cycle in an otherwise good vector -> align_err=1 sticky, no FIFO write, out_vld stays 0.
REQ-033 out_rdy=0 with 6 back-to-back vectors and FIFO_DEPTH=4 -> 4 held, ovf=1 after the 5th vector; releasing out_rdy drains exactly 4 vectors in order.
REQ-034 frame_len=3, 7 vectors -> out_last high on vectors 3 and 6 only; the counter reads 1 at the end.
REQ-035 nrst pulsed while 2 vectors are in flight -> out_vld=0 immediately; the next vector after reset has count 0; align_err=0 and ovf=0.
REQ-036 With OUT_RELU_EN, lane 3 = 16'hFF00 and lane 4 = 16'h0010 -> data_out[3]=0, data_out[4]=16'h0010; without the macro -> 16'hFF00 passes through.
